// File: rtl/led_chaser.sv
// Single-light chaser with wrap and optional ping-pong motion, programmable step period.
// Bounce mode is compiled in only when LED_CHASER_BOUNCE_EN is defined.
module led_chaser #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             dir_i,
  input  logic             bounce_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             wrap_o
);

  localparam int unsigned PosW = $clog2(WIDTH + 1);
  localparam logic [PosW-1:0] PosBlank = PosW'(WIDTH);
  localparam logic [PosW-1:0] PosLast  = PosW'(WIDTH - 1);
  localparam logic [PosW-1:0] PosOne   = PosW'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;

  logic [PosW-1:0]  step_pos;
  logic             step_wrap;

`ifdef LED_CHASER_BOUNCE_EN
  logic mode_q, mode_d;
  logic bdir_q, bdir_d;
  logic step_bdir;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= 1'b0;
      bdir_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      bdir_q <= bdir_d;
    end
  end
`else
  logic unused_bounce;
  assign unused_bounce = bounce_i;
`endif

  // Position reached if a step is taken this cycle.
  always_comb begin
    step_pos  = pos_q;
    step_wrap = 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
    step_bdir = bdir_q;
    if (mode_q) begin
      if (pos_q == PosBlank) begin
        step_pos = bdir_q ? '0 : PosLast;
      end else if (bdir_q) begin
        if (pos_q == PosLast) begin
          step_bdir = 1'b0;
          step_wrap = 1'b1;
          step_pos  = (pos_q == '0) ? pos_q : pos_q - PosOne;
        end else begin
          step_pos = pos_q + PosOne;
        end
      end else begin
        if (pos_q == '0) begin
          step_bdir = 1'b1;
          step_wrap = 1'b1;
          step_pos  = (pos_q == PosLast) ? pos_q : pos_q + PosOne;
        end else begin
          step_pos = pos_q - PosOne;
        end
      end
    end else
`endif
    begin
      if (dir_i) begin
        if (pos_q == PosBlank) begin
          step_pos = '0;
        end else if (pos_q == PosLast) begin
          step_pos  = PosBlank;
          step_wrap = 1'b1;
        end else begin
          step_pos = pos_q + PosOne;
        end
      end else begin
        if (pos_q == PosBlank) begin
          step_pos = PosLast;
        end else if (pos_q == '0) begin
          step_pos  = PosBlank;
          step_wrap = 1'b1;
        end else begin
          step_pos = pos_q - PosOne;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pos_q   <= PosBlank;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  // Stop has priority over start; either one overrides stepping.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
    mode_d  = mode_q;
    bdir_d  = bdir_q;
`endif
    if (stop_i) begin
      state_d = StIdle;
      pos_d   = PosBlank;
      cnt_d   = '0;
    end else if (start_i) begin
      state_d = StRun;
      pos_d   = PosBlank;
      cnt_d   = '0;
`ifdef LED_CHASER_BOUNCE_EN
      mode_d  = bounce_i;
      bdir_d  = dir_i;
`endif
    end else if (state_q == StRun) begin
      if (cnt_q >= div_i) begin
        cnt_d  = '0;
        pos_d  = step_pos;
        wrap_d = step_wrap;
`ifdef LED_CHASER_BOUNCE_EN
        bdir_d = step_bdir;
`endif
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    busy_d = (state_d == StRun);
    out_d  = '0;
    if (pos_d != PosBlank) begin
      out_d = WIDTH'(1) << pos_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign wrap_o = wrap_q;

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter WIDTH, default 4: number of light outputs (1..32).
REQ-002 Parameter DIV_W, default 8: width of the step-divider input.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 start  input  1  level sampled each edge; begins/restarts a run.
REQ-006 stop  input  1  level sampled each edge; ends a run.
REQ-007 dir  input  1  1 = step toward out[WIDTH-1] (left), 0 = toward out[0] (right).
REQ-008 bounce  input  1  1 = ping-pong mode, 0 = wrap mode; sampled only on start.
REQ-009 div  input  DIV_W  step period minus one, in clk cycles.
REQ-010 out  output  WIDTH  registered one-hot light vector, or all-zero.
REQ-011 busy  output  1  registered; 1 while in RUN.
REQ-012 wrap  output  1  registered one-cycle pulse on each wrap/reversal event.

Function
REQ-013 The FSM SHALL have two states: IDLE and RUN.
REQ-014 Position register pos SHALL range 0..WIDTH; pos=WIDTH is the blank slot; out = one-hot(pos) for pos<WIDTH, else all-zero.
REQ-015 In IDLE, out SHALL be 0 and busy 0; the tick counter SHALL hold 0.
REQ-016 start=1 (stop=0) in any state SHALL, on that edge, enter RUN, set pos=WIDTH, clear the tick counter, latch bounce into mode_q and dir into bdir_q.
REQ-017 stop=1 in RUN SHALL return to IDLE on that edge; out=0 and busy=0 from the next cycle.
REQ-018 start=1 and stop=1 on the same edge SHALL be treated as stop (stop wins).
REQ-019 In RUN, the tick counter SHALL increment each cycle; when counter >= div, a step occurs on that edge and the counter clears; div=0 steps every cycle.
REQ-020 A div change mid-run SHALL apply from the next compare; the >= rule prevents lock-up.
REQ-021 Wrap mode, dir=1: pos sequence blank->0->1->...->WIDTH-1->blank, repeating.
REQ-022 Wrap mode, dir=0: pos sequence blank->WIDTH-1->...->0->blank, repeating.
REQ-023 In wrap mode, dir SHALL be sampled at every step; a change takes effect on the next step.
REQ-024 In wrap mode, wrap SHALL pulse high for the one cycle following a step that lands on blank.
REQ-025 Bounce mode: first step from blank enters 0 (bdir_q=1) or WIDTH-1 (bdir_q=0); thereafter pos moves per bdir_q, and a step that would leave 0..WIDTH-1 instead reverses bdir_q and moves one position back inward; blank is never revisited; dir is ignored.
REQ-026 Each bounce reversal SHALL pulse wrap for one cycle.
REQ-027 Bounce with WIDTH=1: out stays 1 after first step; wrap pulses every step.
REQ-028 The new out value SHALL be visible the cycle after the stepping edge (one register stage, no combinational path from inputs to out).

Reset
REQ-029 rst=0 SHALL immediately force IDLE, pos=WIDTH, counter=0, out=0, busy=0, wrap=0, mode_q=0, bdir_q=0, independent of clk.
REQ-030 Reset release SHALL leave the block in IDLE until start is sampled high; no step occurs before that.
REQ-031 Reset mid-run SHALL discard all run state; no wrap pulse is generated by reset.

Configuration
REQ-032 Macro LED_CHASER_BOUNCE_EN: when defined, bounce mode per REQ-025..027 is compiled in.
REQ-033 When LED_CHASER_BOUNCE_EN is undefined, the bounce input SHALL be ignored (mode_q tied to 0), all runs use wrap mode, and no bounce logic is synthesised.

Verification
REQ-034 WIDTH=4, div=0, dir=1, start 1 cycle -> out per cycle: 0000,0001,0010,0100,1000,0000,0001; wrap high the cycle out=0000 after 1000.
REQ-035 WIDTH=4, div=2, dir=0 -> out holds each value 3 cycles: 0000,1000,0100,0010,0001,0000.
REQ-036 Bounce (macro on), WIDTH=4, div=0, dir=1 -> 0000,0001,0010,0100,1000,0100,0010,0001,0010; wrap pulses after 1000 and after 0001.
REQ-037 start and stop both high during RUN -> IDLE next cycle, out=0000, busy=0; start alone while in RUN -> run restarts at blank.
REQ-038 rst=0 asserted mid-cycle while out=0100 -> out=0000, busy=0 without clk edge; after release, out stays 0000 until start.
REQ-039 Macro off, bounce=1, dir=1, div=0 -> identical sequence to REQ-034.
